cam_init_seq: RTL
=================

# cam_init_seq

Camera register-configuration sequencer that sits directly upstream of the SCCB/I2C byte-frame writer. On `start` it waits a power-up delay, then walks an internal table of 24-bit writes ({16-bit register address, 8-bit value}) and presents each entry to the writer with the writer's level `sendit` / `done` handshake. It checks the sticky NACK flag and retries failed writes, honours table-embedded millisecond delays, and reports completion or error to the top-level VGA/camera pipeline.

## Interface
- `NUM_REGS`, 64: table entries used, 1..256.
- `PWRUP_MS`, 20: delay after `start` before the first write.
- `CYCLES_PER_MS`, 25000: `meg25` cycles per millisecond.
- `GAP_CYCLES`, 300: `sendit`-low time between frames. Must be ≥ 2 writer bit periods (252).
- `TIMEOUT_CYCLES`, 20000: maximum wait for `i2c_done` per frame.
- `MAX_RETRY`, 3: extra attempts per entry after a NACK or timeout.

- `meg25` in 1: 25 MHz system clock, the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: a rising edge, sampled in IDLE, begins a configuration run.
- `i2c_done` in 1: writer frame-complete level.
- `i2c_ack` in 1: writer sticky NACK flag (1 = a byte was not acknowledged).
- `send_dat` out 24: {addr[15:0], data[7:0]} for the writer.
- `sendit` out 1: level request to the writer.
- `i2c_ack_clr` out 1: one-cycle pulse wired to the writer's `reset` to clear the sticky NACK.
- `busy` out 1: high from the `start` edge until DONE/ERROR.
- `config_done` out 1: held high after the last entry succeeds.
- `config_err` out 1: held high after the retries are exhausted.
- `reg_index` out 8: index of the current or failing entry.

## Operation
- States: IDLE, PWRUP, LOAD, CLR, SEND, GAP, DELAY, DONE, ERROR.
- **IDLE**
  - All outputs 0.
  - A `start` rising edge clears `reg_index`, `config_done`, `config_err` and the retry count, then enters PWRUP.
- **PWRUP**: counts PWRUP_MS × CYCLES_PER_MS cycles, then goes to LOAD.
- **LOAD**
  - Registers the ROM entry at `reg_index` into `send_dat`.
  - If addr == 16'hFFFF the entry is a delay: go to DELAY for data[7:0] ms. Data 0 means zero wait.
  - Otherwise go to CLR.
- **CLR**: asserts `i2c_ack_clr` for exactly 1 cycle, then goes to SEND.
- **SEND**
  - `sendit` = 1, and `send_dat` is held stable for the whole state.
  - Exits on the first cycle `i2c_done` = 1. The bad flag is (`i2c_ack` == 1).
  - Also exits with bad = 1 if TIMEOUT_CYCLES elapse first.
  - Goes to GAP.
- **GAP**
  - `sendit` = 0 for GAP_CYCLES.
  - If bad and retries < MAX_RETRY: increment the retry count and go to LOAD with the same index.
  - If bad and retries exhausted: go to ERROR.
  - If good: clear the retry count, increment `reg_index`, then go to LOAD, or to DONE if the new index == NUM_REGS.
- **DELAY**: counts data × CYCLES_PER_MS cycles, increments `reg_index`, then goes to LOAD or DONE by the same rule as GAP.
- **DONE / ERROR**
  - Latch `config_done` / `config_err` respectively; `busy` = 0.
  - Next `start` edge re-runs the table from index 0.
  - In ERROR, `reg_index` holds the failing entry.
- **Reset mid-operation**: asynchronous return to IDLE with every output 0.
  - `sendit` dropping to 0 aborts the writer's frame.
  - The bus may be left mid-byte; the next frame's START recovers it.
- `start` edges while `busy` are ignored.

## Timing
- Registered outputs only; no combinational path from any input to any output.
- `start` edge → `busy` = 1 next cycle.
- Write request latency: LOAD (1) + CLR (1) → `sendit` high 2 cycles after entering LOAD.
- `i2c_done` = 1 → `sendit` = 0 on the next cycle.
- Per good entry, total time = 2 + frame time + GAP_CYCLES.
- Counters:
  - Delay counter is 24 bits wide (255 × 25000 fits); terminal count is compared exactly, with no wrap.
  - `reg_index` is 9 bits internally; the output is [7:0].

## Structure
- Package `cam_cfg_pkg`:
  - state enum;
  - `DELAY_TAG` = 16'hFFFF;
  - the 24-bit entry type;
  - parameter defaults.
- Sub-module `cam_reg_rom`: purely combinational lookup, `index[7:0]` → `entry[23:0]`, holding the OV5640 table. Unused indices return {DELAY_TAG, 8'd0}.

## Test plan
- NUM_REGS = 2, entries {3008,82}, {3103,03}, writer model acks all:
  - `send_dat` shows 24'h300882 then 24'h310303;
  - `config_done` = 1; 2 `i2c_ack_clr` pulses.
- Entry 0 NACKed twice then acked, MAX_RETRY = 3:
  - 3 frames for 24'h300882, `reg_index` stays 0 across all three;
  - ends with `config_done` = 1.
- Entry 1 NACKed on 4 attempts:
  - `config_err` = 1, `reg_index` = 1, `busy` = 0;
  - `sendit` never rises again.
- Table entry {FFFF,05} with CYCLES_PER_MS = 10:
  - exactly 50 cycles with `sendit` = 0 in DELAY;
  - the next entry's `sendit` rises 2 cycles later.
- Writer never asserts `i2c_done`, TIMEOUT_CYCLES = 100, MAX_RETRY = 0:
  - `sendit` falls after 100 cycles, then `config_err` = 1.
- `reset` pulsed mid-SEND:
  - `sendit`, `busy` and `i2c_ack_clr` are 0 in the same cycle;
  - a following `start` restarts from index 0 with the full PWRUP delay.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera register-configuration sequencer.
// Holds the sequencer state encoding, the table entry layout, the delay
// marker address and the default timing parameters.
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPwrup,
        StLoad,
        StClr,
        StSend,
        StGap,
        StDelay,
        StDone,
        StError
    } cfg_state_e;

    // Table entries with this address are waits, not register writes.
    localparam logic [15:0] DELAY_TAG = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    localparam int unsigned DEF_NUM_REGS       = 64;
    localparam int unsigned DEF_PWRUP_MS       = 20;
    localparam int unsigned DEF_CYCLES_PER_MS  = 25000;
    localparam int unsigned DEF_GAP_CYCLES     = 300;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 20000;
    localparam int unsigned DEF_MAX_RETRY      = 3;

    function automatic logic is_delay(input cfg_entry_t e);
        return e.addr == DELAY_TAG;
    endfunction

endpackage

// File: rtl/cam_reg_rom.sv
// OV5640 configuration table (VGA, RGB565), purely combinational.
// Ports:
//   index - table entry number
//   entry - {register address, value}; unused indices read as a zero-length wait
module cam_reg_rom
    import cam_cfg_pkg::*;
(
    input  logic [7:0] index,
    output cfg_entry_t entry
);

    always_comb begin
        entry = '{addr: DELAY_TAG, data: 8'h00};
        case (index)
            8'd0:  entry = '{addr: 16'h3008, data: 8'h82};  // software reset
            8'd1:  entry = '{addr: 16'h3103, data: 8'h03};  // clock from PLL
            8'd2:  entry = '{addr: DELAY_TAG, data: 8'h05}; // let the reset settle
            8'd3:  entry = '{addr: 16'h3017, data: 8'hFF};
            8'd4:  entry = '{addr: 16'h3018, data: 8'hFF};
            8'd5:  entry = '{addr: 16'h3034, data: 8'h1A};
            8'd6:  entry = '{addr: 16'h3037, data: 8'h13};
            8'd7:  entry = '{addr: 16'h3108, data: 8'h01};
            8'd8:  entry = '{addr: 16'h3630, data: 8'h36};
            8'd9:  entry = '{addr: 16'h3631, data: 8'h0E};
            8'd10: entry = '{addr: 16'h3632, data: 8'hE2};
            8'd11: entry = '{addr: 16'h3633, data: 8'h12};
            8'd12: entry = '{addr: 16'h3621, data: 8'hE0};
            8'd13: entry = '{addr: 16'h3704, data: 8'hA0};
            8'd14: entry = '{addr: 16'h3703, data: 8'h5A};
            8'd15: entry = '{addr: 16'h3715, data: 8'h78};
            8'd16: entry = '{addr: 16'h3717, data: 8'h01};
            8'd17: entry = '{addr: 16'h370B, data: 8'h60};
            8'd18: entry = '{addr: 16'h3705, data: 8'h1A};
            8'd19: entry = '{addr: 16'h3905, data: 8'h02};
            8'd20: entry = '{addr: 16'h3906, data: 8'h10};
            8'd21: entry = '{addr: 16'h3901, data: 8'h0A};
            8'd22: entry = '{addr: 16'h3731, data: 8'h12};
            8'd23: entry = '{addr: 16'h3600, data: 8'h08};
            8'd24: entry = '{addr: 16'h3601, data: 8'h33};
            8'd25: entry = '{addr: 16'h3808, data: 8'h02};  // width 640
            8'd26: entry = '{addr: 16'h3809, data: 8'h80};
            8'd27: entry = '{addr: 16'h380A, data: 8'h01};  // height 480
            8'd28: entry = '{addr: 16'h380B, data: 8'hE0};
            8'd29: entry = '{addr: 16'h4300, data: 8'h61};  // RGB565
            8'd30: entry = '{addr: 16'h501F, data: 8'h01};
            8'd31: entry = '{addr: 16'h3008, data: 8'h02};  // wake from standby
            default: ;
        endcase
    end

endmodule

// File: rtl/cam_init_seq.sv
// Camera configuration sequencer feeding an SCCB/I2C byte-frame writer.
// After start and a power-up wait it walks the register table, handing each
// write to the writer with a level sendit/done handshake, retrying NACKed or
// timed-out frames and honouring embedded millisecond waits.
// Ports:
//   meg25       - 25 MHz clock
//   reset       - asynchronous active-high reset
//   start       - rising edge starts a run when not busy
//   i2c_done    - writer frame complete (level)
//   i2c_ack     - writer sticky NACK flag
//   send_dat    - {addr, data} of the current write
//   sendit      - write request level
//   i2c_ack_clr - one-cycle clear of the writer's NACK flag
//   busy        - run in progress
//   config_done - table completed
//   config_err  - retries exhausted
//   reg_index   - current or failing table index
module cam_init_seq
    import cam_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
    parameter int unsigned PWRUP_MS       = DEF_PWRUP_MS,
    parameter int unsigned CYCLES_PER_MS  = DEF_CYCLES_PER_MS,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic        meg25,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic [23:0] send_dat,
    output logic        sendit,
    output logic        i2c_ack_clr,
    output logic        busy,
    output logic        config_done,
    output logic        config_err,
    output logic [7:0]  reg_index
);

    localparam logic [23:0] PWRUP_CNT = 24'(PWRUP_MS * CYCLES_PER_MS);
    localparam logic [23:0] GAP_CNT   = 24'(GAP_CYCLES);
    localparam logic [23:0] TMO_CNT   = 24'(TIMEOUT_CYCLES);
    localparam logic [8:0]  END_IDX   = 9'(NUM_REGS);

    cfg_state_e  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [8:0]  idx_q, idx_d, idx_next;
    logic [7:0]  retry_q, retry_d;
    logic        bad_q, bad_d;
    logic        start_q;
    logic        start_edge;
    cfg_entry_t  rom_entry;
    cfg_entry_t  dat_q, dat_d;
    logic [23:0] delay_cnt;
    logic        sendit_q, clr_q, busy_q, done_q, err_q;

    cam_reg_rom u_rom (
        .index (idx_q[7:0]),
        .entry (rom_entry)
    );

    assign start_edge = start & ~start_q;
    assign idx_next   = idx_q + 9'd1;
    assign delay_cnt  = 24'(32'(rom_entry.data) * CYCLES_PER_MS);

    // cnt_q is a down-counter loaded on state entry; a state ends when it
    // reaches 1, so each timed state lasts max(load value, 1) cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        bad_d   = bad_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_edge) begin
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = PWRUP_CNT;
                    state_d = StPwrup;
                end
            end
            StPwrup: begin
                if (cnt_q <= 24'd1) state_d = StLoad;
                else                cnt_d   = cnt_q - 24'd1;
            end
            StLoad: begin
                dat_d = rom_entry;
                if (is_delay(rom_entry)) begin
                    cnt_d   = delay_cnt;
                    state_d = StDelay;
                end else begin
                    state_d = StClr;
                end
            end
            StClr: begin
                cnt_d   = TMO_CNT;
                state_d = StSend;
            end
            StSend: begin
                if (i2c_done) begin
                    bad_d   = i2c_ack;
                    cnt_d   = GAP_CNT;
                    state_d = StGap;
                end else if (cnt_q <= 24'd1) begin
                    bad_d   = 1'b1;
                    cnt_d   = GAP_CNT;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            StGap: begin
                if (cnt_q > 24'd1) begin
                    cnt_d = cnt_q - 24'd1;
                end else if (!bad_q) begin
                    retry_d = '0;
                    idx_d   = idx_next;
                    state_d = (idx_next == END_IDX) ? StDone : StLoad;
                end else if (32'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + 8'd1;
                    state_d = StLoad;
                end else begin
                    state_d = StError;
                end
            end
            StDelay: begin
                if (cnt_q > 24'd1) begin
                    cnt_d = cnt_q - 24'd1;
                end else begin
                    idx_d   = idx_next;
                    state_d = (idx_next == END_IDX) ? StDone : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge meg25 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            bad_q    <= 1'b0;
            start_q  <= 1'b0;
            dat_q    <= '0;
            sendit_q <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            bad_q    <= bad_d;
            start_q  <= start;
            dat_q    <= dat_d;
            sendit_q <= (state_d == StSend);
            clr_q    <= (state_d == StClr);
            busy_q   <= !(state_d inside {StIdle, StDone, StError});
            done_q   <= (state_d == StDone);
            err_q    <= (state_d == StError);
        end
    end

    assign send_dat    = dat_q;
    assign sendit      = sendit_q;
    assign i2c_ack_clr = clr_q;
    assign busy        = busy_q;
    assign config_done = done_q;
    assign config_err  = err_q;
    assign reg_index   = idx_q[7:0];

endmodule
